// File: rtl/mesi_coherence_monitor_if.sv
// rtl/mesi_coherence_monitor_if.sv - signal bundle between the mesi_isc bench and the coherence monitor
`ifndef MESI_ISC_TB_CPU_MESI_M
`define MESI_ISC_TB_CPU_MESI_M 4'b1001
`endif
`ifndef MESI_ISC_TB_CPU_MESI_E
`define MESI_ISC_TB_CPU_MESI_E 4'b0101
`endif
`ifndef MESI_ISC_TB_CPU_MESI_S
`define MESI_ISC_TB_CPU_MESI_S 4'b0011
`endif
`ifndef MESI_ISC_TB_CPU_MESI_I
`define MESI_ISC_TB_CPU_MESI_I 4'b0000
`endif
`ifndef MESI_ISC_TB_INS_NOP
`define MESI_ISC_TB_INS_NOP 4'd0
`endif
`ifndef MESI_ISC_TB_INS_WR
`define MESI_ISC_TB_INS_WR 4'd1
`endif
`ifndef MESI_ISC_TB_INS_RD
`define MESI_ISC_TB_INS_RD 4'd2
`endif

interface mesi_coherence_monitor_if #(
  parameter int N_CPU   = 4,
  parameter int N_LINES = 10,
  parameter int ADDR_W  = 4,
  parameter int CNT_W   = 16
);
  logic [N_CPU*N_LINES*4-1:0] cache_state_i;
  logic [N_CPU*4-1:0]         ins_i;
  logic [N_CPU*ADDR_W-1:0]    ins_addr_i;
  logic [N_CPU-1:0]           ins_ack_i;
  logic                       clr_i;
  logic                       swmr_err_o;
  logic [N_CPU-1:0]           starve_err_o;
  logic                       err_valid_o;
  logic [2:0]                 err_code_o;
  logic [2:0]                 err_cpu_o;
  logic [3:0]                 err_line_o;
  logic [CNT_W-1:0]           err_cnt_o;

  modport master (
    output cache_state_i, ins_i, ins_addr_i, ins_ack_i, clr_i,
    input  swmr_err_o, starve_err_o, err_valid_o, err_code_o, err_cpu_o, err_line_o, err_cnt_o
  );

  modport slave (
    input  cache_state_i, ins_i, ins_addr_i, ins_ack_i, clr_i,
    output swmr_err_o, starve_err_o, err_valid_o, err_code_o, err_cpu_o, err_line_o, err_cnt_o
  );
endinterface

// File: rtl/mesi_coherence_monitor.sv
// rtl/mesi_coherence_monitor.sv - MESI legality checker with per-CPU write (and optional read, MESI_ISC_MON_RD_TRACK_EN) starvation trackers
module mesi_coherence_monitor #(
  parameter int N_CPU   = 4,
  parameter int N_LINES = 10,
  parameter int ADDR_W  = 4,
  parameter int TIMEOUT = 500,
  parameter int CNT_W   = 16
) (
  input logic clk,
  input logic rst,
  mesi_coherence_monitor_if.slave bus
);
  localparam logic [3:0]  ST_M   = `MESI_ISC_TB_CPU_MESI_M;
  localparam logic [3:0]  ST_E   = `MESI_ISC_TB_CPU_MESI_E;
  localparam logic [3:0]  ST_S   = `MESI_ISC_TB_CPU_MESI_S;
  localparam logic [3:0]  ST_I   = `MESI_ISC_TB_CPU_MESI_I;
  localparam logic [3:0]  INS_WR = `MESI_ISC_TB_INS_WR;
  localparam logic [3:0]  INS_RD = `MESI_ISC_TB_INS_RD;
  localparam logic [15:0] TMO_M1 = 16'(TIMEOUT - 1);
  localparam int          SUM_W  = CNT_W + 8;

  typedef enum logic {TRK_IDLE, TRK_WAIT} trk_t;

  logic [3:0]        st [N_CPU][N_LINES];
  logic [3:0]        op [N_CPU];
  logic [ADDR_W-1:0] addr [N_CPU];
  logic [N_CPU-1:0]  in_range;
  logic [N_CPU-1:0]  range_ev;

  logic [N_LINES-1:0] conf_me, conf_s, bad_enc;
  logic [2:0]         me_cpu [N_LINES];
  logic [2:0]         bad_cpu [N_LINES];

  trk_t              wr_st [N_CPU];
  trk_t              wr_st_nx [N_CPU];
  logic [15:0]       wr_tmr [N_CPU];
  logic [15:0]       wr_tmr_nx [N_CPU];
  logic [ADDR_W-1:0] wr_line [N_CPU];
  logic [ADDR_W-1:0] wr_line_nx [N_CPU];
  logic [N_CPU-1:0]  wr_to;
  logic [N_CPU-1:0]  rd_to;

  logic [7:0]       ev_cnt;
  logic [9:0]       best;
  logic [SUM_W-1:0] sum_w;
  logic [CNT_W-1:0] cnt_nx;

  logic             swmr_r;
  logic [N_CPU-1:0] starve_r;
  logic             valid_r;
  logic [2:0]       code_r, cpu_r;
  logic [3:0]       line_r;
  logic [CNT_W-1:0] cnt_r;

  // unpack flat input buses into per-CPU views
  always_comb begin
    range_ev = '0;
    in_range = '0;
    for (int c = 0; c < N_CPU; c++) begin
      op[c]   = bus.ins_i[c*4 +: 4];
      addr[c] = bus.ins_addr_i[c*ADDR_W +: ADDR_W];
      in_range[c] = 32'(addr[c]) < 32'(N_LINES);
`ifdef MESI_ISC_MON_RD_TRACK_EN
      range_ev[c] = bus.ins_ack_i[c] && (op[c] == INS_WR || op[c] == INS_RD) && !in_range[c];
`else
      range_ev[c] = bus.ins_ack_i[c] && op[c] == INS_WR && !in_range[c];
`endif
      for (int l = 0; l < N_LINES; l++)
        st[c][l] = bus.cache_state_i[(c*N_LINES+l)*4 +: 4];
    end
  end

  // per-line legality: count M/E holders, note S holders and illegal encodings (scan high-to-low so lowest CPU wins)
  always_comb begin
    logic [3:0] n_me;
    logic       any_s;
    conf_me = '0;
    conf_s  = '0;
    bad_enc = '0;
    n_me    = '0;
    any_s   = 1'b0;
    for (int l = 0; l < N_LINES; l++) begin
      me_cpu[l]  = '0;
      bad_cpu[l] = '0;
      n_me       = '0;
      any_s      = 1'b0;
      for (int c = N_CPU-1; c >= 0; c--) begin
        if (st[c][l] == ST_M || st[c][l] == ST_E) begin
          n_me      = n_me + 4'd1;
          me_cpu[l] = 3'(c);
        end else if (st[c][l] == ST_S) begin
          any_s = 1'b1;
        end else if (st[c][l] != ST_I) begin
          bad_enc[l] = 1'b1;
          bad_cpu[l] = 3'(c);
        end
      end
      conf_me[l] = n_me > 4'd1;
      conf_s[l]  = (n_me != 4'd0) && any_s;
    end
  end

  // write tracker next state: an in-range WR accept always (re)arms; otherwise wait for M or time out
  always_comb begin
    logic [3:0] cur;
    wr_to = '0;
    cur   = ST_I;
    for (int c = 0; c < N_CPU; c++) begin
      wr_st_nx[c]   = wr_st[c];
      wr_tmr_nx[c]  = wr_tmr[c];
      wr_line_nx[c] = wr_line[c];
      cur = ST_I;
      for (int l = 0; l < N_LINES; l++)
        if (wr_line[c] == ADDR_W'(l)) cur = st[c][l];
      if (bus.ins_ack_i[c] && op[c] == INS_WR && in_range[c]) begin
        wr_st_nx[c]   = TRK_WAIT;
        wr_tmr_nx[c]  = '0;
        wr_line_nx[c] = addr[c];
      end else if (wr_st[c] == TRK_WAIT) begin
        if (cur == ST_M) begin
          wr_st_nx[c] = TRK_IDLE;
        end else if (wr_tmr[c] == TMO_M1) begin
          wr_st_nx[c] = TRK_IDLE;
          wr_to[c]    = 1'b1;
        end else begin
          wr_tmr_nx[c] = wr_tmr[c] + 16'd1;
        end
      end
    end
  end

  // write tracker state registers
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      for (int c = 0; c < N_CPU; c++) begin
        wr_st[c]   <= TRK_IDLE;
        wr_tmr[c]  <= '0;
        wr_line[c] <= '0;
      end
    end else begin
      for (int c = 0; c < N_CPU; c++) begin
        wr_st[c]   <= wr_st_nx[c];
        wr_tmr[c]  <= wr_tmr_nx[c];
        wr_line[c] <= wr_line_nx[c];
      end
    end
  end

`ifdef MESI_ISC_MON_RD_TRACK_EN
  trk_t              rd_st [N_CPU];
  trk_t              rd_st_nx [N_CPU];
  logic [15:0]       rd_tmr [N_CPU];
  logic [15:0]       rd_tmr_nx [N_CPU];
  logic [ADDR_W-1:0] rd_line [N_CPU];
  logic [ADDR_W-1:0] rd_line_nx [N_CPU];

  // read tracker next state: arms only when the requested line is I, completes on E or S
  always_comb begin
    logic [3:0] cur;
    logic [3:0] req;
    rd_to = '0;
    cur   = ST_I;
    req   = ST_I;
    for (int c = 0; c < N_CPU; c++) begin
      rd_st_nx[c]   = rd_st[c];
      rd_tmr_nx[c]  = rd_tmr[c];
      rd_line_nx[c] = rd_line[c];
      cur = ST_I;
      req = ST_I;
      for (int l = 0; l < N_LINES; l++) begin
        if (rd_line[c] == ADDR_W'(l)) cur = st[c][l];
        if (addr[c] == ADDR_W'(l)) req = st[c][l];
      end
      if (bus.ins_ack_i[c] && op[c] == INS_RD && in_range[c] && req == ST_I) begin
        rd_st_nx[c]   = TRK_WAIT;
        rd_tmr_nx[c]  = '0;
        rd_line_nx[c] = addr[c];
      end else if (rd_st[c] == TRK_WAIT) begin
        if (cur == ST_E || cur == ST_S) begin
          rd_st_nx[c] = TRK_IDLE;
        end else if (rd_tmr[c] == TMO_M1) begin
          rd_st_nx[c] = TRK_IDLE;
          rd_to[c]    = 1'b1;
        end else begin
          rd_tmr_nx[c] = rd_tmr[c] + 16'd1;
        end
      end
    end
  end

  // read tracker state registers
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      for (int c = 0; c < N_CPU; c++) begin
        rd_st[c]   <= TRK_IDLE;
        rd_tmr[c]  <= '0;
        rd_line[c] <= '0;
      end
    end else begin
      for (int c = 0; c < N_CPU; c++) begin
        rd_st[c]   <= rd_st_nx[c];
        rd_tmr[c]  <= rd_tmr_nx[c];
        rd_line[c] <= rd_line_nx[c];
      end
    end
  end
`else
  assign rd_to = '0;
`endif

  // count this cycle's events and pick the smallest {code, cpu, line} key for capture
  always_comb begin
    logic [9:0] key;
    ev_cnt = '0;
    best   = '1;
    key    = '1;
    for (int l = 0; l < N_LINES; l++) begin
      if (conf_me[l]) begin
        ev_cnt = ev_cnt + 8'd1;
        key = {3'd1, me_cpu[l], 4'(l)};
        if (key < best) best = key;
      end
      if (conf_s[l]) begin
        ev_cnt = ev_cnt + 8'd1;
        key = {3'd2, me_cpu[l], 4'(l)};
        if (key < best) best = key;
      end
      if (bad_enc[l]) begin
        ev_cnt = ev_cnt + 8'd1;
        key = {3'd3, bad_cpu[l], 4'(l)};
        if (key < best) best = key;
      end
    end
    for (int c = 0; c < N_CPU; c++) begin
      if (wr_to[c]) begin
        ev_cnt = ev_cnt + 8'd1;
        key = {3'd4, 3'(c), 4'(wr_line[c])};
        if (key < best) best = key;
      end
      if (range_ev[c]) begin
        ev_cnt = ev_cnt + 8'd1;
        key = {3'd5, 3'(c), 4'(addr[c])};
        if (key < best) best = key;
      end
`ifdef MESI_ISC_MON_RD_TRACK_EN
      if (rd_to[c]) begin
        ev_cnt = ev_cnt + 8'd1;
        key = {3'd6, 3'(c), 4'(rd_line[c])};
        if (key < best) best = key;
      end
`endif
    end
  end

  // saturating counter update; clear drops the old count but still adds this cycle's events
  always_comb begin
    sum_w  = (bus.clr_i ? '0 : SUM_W'(cnt_r)) + SUM_W'(ev_cnt);
    cnt_nx = (sum_w > SUM_W'({CNT_W{1'b1}})) ? '1 : sum_w[CNT_W-1:0];
  end

  // registered error outputs and first-error capture
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      swmr_r   <= 1'b0;
      starve_r <= '0;
      valid_r  <= 1'b0;
      code_r   <= '0;
      cpu_r    <= '0;
      line_r   <= '0;
      cnt_r    <= '0;
    end else begin
      swmr_r   <= |(conf_me | conf_s | bad_enc);
      starve_r <= wr_to | rd_to;
      cnt_r    <= cnt_nx;
      if (bus.clr_i) begin
        valid_r <= 1'b0;
        code_r  <= '0;
        cpu_r   <= '0;
        line_r  <= '0;
      end
      if (ev_cnt != 8'd0 && (bus.clr_i || !valid_r)) begin
        valid_r <= 1'b1;
        code_r  <= best[9:7];
        cpu_r   <= best[6:4];
        line_r  <= best[3:0];
      end
    end
  end

  assign bus.swmr_err_o   = swmr_r;
  assign bus.starve_err_o = starve_r;
  assign bus.err_valid_o  = valid_r;
  assign bus.err_code_o   = code_r;
  assign bus.err_cpu_o    = cpu_r;
  assign bus.err_line_o   = line_r;
  assign bus.err_cnt_o    = cnt_r;
endmodule
